// File: rtl/uart_8n1_pkg.sv
// Shared definitions for the 8N1 UART transmitter: framing constants and FSM state type.
package uart_8n1_pkg;

  localparam int UART_DATA_BITS          = 8;
  localparam int UART_OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Phase counter for one UART bit: pulses bit_end_o on the last of every OVERSAMPLE cycles.
// Optional checks compiled in with UART_8N1_TX_ASSERT_EN.
module uart_tx_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic run_i,
  output logic bit_end_o
);

  localparam int CNT_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] phase_q;
  logic [CNT_W-1:0] phase_d;

  assign bit_end_o = run_i && (phase_q == LAST);

  // Next phase: held at zero while idle or on accept, otherwise wraps at LAST.
  always_comb begin
    phase_d = phase_q;
    if (clear_i || !run_i) begin
      phase_d = '0;
    end else if (phase_q == LAST) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + 1'b1;
    end
  end

  // Phase register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

`ifdef UART_8N1_TX_ASSERT_EN
  // Phase must never leave the 0..OVERSAMPLE-1 range.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (32'(phase_q) < 32'(OVERSAMPLE))
        else $error("uart_tx_bit_timer: phase %0d out of range", phase_q);
    end
  end
`else
`endif

endmodule

// File: rtl/uart_8n1_transmitter.sv
// 8N1 UART transmitter: start bit, eight data bits LSB first, stop bit, OVERSAMPLE clocks per bit.
// Define UART_8N1_TX_ASSERT_EN to compile in simulation-only protocol checks.
module uart_8n1_transmitter
  import uart_8n1_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT
) (
  input  logic       clk_baud_16x,
  input  logic       reset,
  input  logic [7:0] trans_data,
  input  logic       trans_write,
  output logic       trans_busy,
  output logic       tx
);

  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

  uart_tx_state_t            state_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [IDX_W-1:0]          bit_idx_q;
  logic                      tx_q;
  logic                      busy_q;
  logic                      accept_s;
  logic                      bit_end_s;

  assign accept_s   = (state_q == IDLE) && trans_write;
  assign trans_busy = busy_q;
  assign tx         = tx_q;

  uart_tx_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk_i     (clk_baud_16x),
    .rst_i     (reset),
    .clear_i   (accept_s),
    .run_i     (state_q != IDLE),
    .bit_end_o (bit_end_s)
  );

  // Frame sequencer; tx and busy are registered alongside the state.
  always_ff @(posedge clk_baud_16x or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trans_write) begin
            state_q   <= START;
            shift_q   <= trans_data;
            bit_idx_q <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end else begin
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        START: begin
          if (bit_end_s) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_end_s) begin
            shift_q <= shift_q >> 1;
            if (bit_idx_q == LAST_IDX) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              tx_q      <= shift_q[1];
            end
          end
        end
        STOP: begin
          if (bit_end_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_8N1_TX_ASSERT_EN
  int unsigned busy_cycles_q;

  // Length of the current busy run, restarted whenever busy is low.
  always_ff @(posedge clk_baud_16x or posedge reset) begin
    if (reset) begin
      busy_cycles_q <= 32'd0;
    end else if (busy_q) begin
      busy_cycles_q <= busy_cycles_q + 32'd1;
    end else begin
      busy_cycles_q <= 32'd0;
    end
  end

  // Line idles high when not busy; every completed frame is exactly ten bit times.
  always @(posedge clk_baud_16x) begin
    if (!reset) begin
      assert (busy_q || tx_q)
        else $error("uart_8n1_transmitter: tx low while not busy");
      if (!busy_q && (busy_cycles_q != 32'd0)) begin
        assert (busy_cycles_q == 32'(10 * OVERSAMPLE))
          else $error("uart_8n1_transmitter: busy lasted %0d cycles", busy_cycles_q);
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_uart_8n1_transmitter.sv
// Self-checking bench for uart_8n1_transmitter: frame-offset reference model plus a mid-bit receiver.
module tb_uart_8n1_transmitter;

  localparam int OS        = 16;
  localparam int FRAME_LEN = 10 * OS;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] trans_data;
  logic       trans_write;
  logic       trans_busy;
  logic       tx;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model: a frame is a byte plus the cycle offset since its accept edge
  bit         m_active = 1'b0;
  int         m_off    = 0;
  logic [7:0] m_byte   = 8'h00;
  int         m_frames = 0;
  logic [7:0] exp_bytes[$];

  // receiver / observers on the DUT outputs
  bit         rx_on     = 1'b0;
  int         rx_cnt    = 0;
  logic [7:0] rx_byte   = 8'h00;
  bit         prev_busy = 1'b0;
  int         busy_run  = 0;
  int         dut_rises = 0;
  int         rise_cyc[$];

  always #5 clk = ~clk;

  uart_8n1_transmitter #(.OVERSAMPLE(OS)) dut (
    .clk_baud_16x (clk),
    .reset        (reset),
    .trans_data   (trans_data),
    .trans_write  (trans_write),
    .trans_busy   (trans_busy),
    .tx           (tx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic exp_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_off / OS;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[b-1];
    return 1'b1;
  endfunction

  task automatic drop_frames();
    m_active  = 1'b0;
    rx_on     = 1'b0;
    busy_run  = 0;
    prev_busy = 1'b0;
    exp_bytes.delete();
  endtask

  // one clock: update the model at the edge, compare at the following falling edge
  task automatic clk_cycle();
    logic [7:0] want;
    @(posedge clk);
    if (reset) begin
      drop_frames();
    end else if (m_active) begin
      m_off++;
      if (m_off == FRAME_LEN) m_active = 1'b0;
    end else if (trans_write) begin
      m_active = 1'b1;
      m_off    = 0;
      m_byte   = trans_data;
      m_frames++;
      exp_bytes.push_back(trans_data);
    end
    cyc++;
    @(negedge clk);
    check("busy", {31'd0, trans_busy}, {31'd0, m_active});
    check("tx", {31'd0, tx}, {31'd0, exp_tx()});

    if (trans_busy && !prev_busy) begin
      dut_rises++;
      rise_cyc.push_back(cyc);
      rx_on  = 1'b1;
      rx_cnt = 0;
    end else if (rx_on) begin
      rx_cnt++;
    end
    if (rx_on) begin
      if (rx_cnt == OS / 2) check("rx_start", {31'd0, tx}, 32'd0);
      if (rx_cnt >= OS + OS / 2 && rx_cnt < 9 * OS && (rx_cnt % OS) == OS / 2)
        rx_byte[rx_cnt / OS - 1] = tx;
      if (rx_cnt == 9 * OS + OS / 2) begin
        check("rx_stop", {31'd0, tx}, 32'd1);
        want = (exp_bytes.size() != 0) ? exp_bytes.pop_front() : 8'hxx;
        check("rx_byte", {24'd0, rx_byte}, {24'd0, want});
        rx_on = 1'b0;
      end
    end

    if (trans_busy) begin
      busy_run++;
    end else if (busy_run > 0) begin
      check("busy_len", busy_run, FRAME_LEN);
      busy_run = 0;
    end
    prev_busy = trans_busy;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) clk_cycle();
  endtask

  initial begin
    int base_frames;
    int base_rises;
    int t0;
    int gap;
    int hold;
    int chg;

    reset       = 1'b1;
    trans_write = 1'b0;
    trans_data  = 8'h00;

    // reset held for two cycles, then idle
    run(2);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, trans_busy}, 32'd0);
    reset = 1'b0;
    run(5);
    check("idle_tx", {31'd0, tx}, 32'd1);

    // single 0x42 frame from a one-cycle pulse
    trans_data  = 8'h42;
    trans_write = 1'b1;
    clk_cycle();
    trans_write = 1'b0;
    run(FRAME_LEN + 10);
    check("pulse_frames", dut_rises, 1);

    // write held for 400 cycles: back-to-back frames 161 cycles apart, exactly three of them
    base_frames = m_frames;
    base_rises  = dut_rises;
    t0          = rise_cyc.size();
    trans_write = 1'b1;
    run(400);
    trans_write = 1'b0;
    run(200);
    check("held_frames_model", m_frames - base_frames, 3);
    check("held_frames_dut", dut_rises - base_rises, 3);
    if (rise_cyc.size() >= t0 + 3) begin
      check("period_1", rise_cyc[t0+1] - rise_cyc[t0], FRAME_LEN + 1);
      check("period_2", rise_cyc[t0+2] - rise_cyc[t0+1], FRAME_LEN + 1);
    end else begin
      check("held_rises", rise_cyc.size() - t0, 3);
    end

    // data changed mid-frame must not affect the frame; ignored write while busy
    trans_data  = 8'h42;
    trans_write = 1'b1;
    clk_cycle();
    trans_write = 1'b0;
    run(40);
    trans_data  = 8'hCA;
    trans_write = 1'b1;
    run(3);
    trans_write = 1'b0;
    run(FRAME_LEN);
    trans_write = 1'b1;
    clk_cycle();
    trans_write = 1'b0;
    run(FRAME_LEN + 5);

    // reset at offset 70 of a frame, then a clean frame afterwards
    trans_data  = 8'h5A;
    trans_write = 1'b1;
    clk_cycle();
    trans_write = 1'b0;
    run(70);
    reset = 1'b1;
    #1;
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_busy", {31'd0, trans_busy}, 32'd0);
    drop_frames();
    run(2);
    reset = 1'b0;
    run(3);
    trans_data  = 8'hA5;
    trans_write = 1'b1;
    clk_cycle();
    trans_write = 1'b0;
    run(FRAME_LEN + 5);

    // write held high across reset release: frame starts on the first edge with reset low
    @(negedge clk);
    reset       = 1'b1;
    trans_write = 1'b1;
    trans_data  = 8'h3C;
    drop_frames();
    run(2);
    base_rises = dut_rises;
    reset      = 1'b0;
    clk_cycle();
    check("release_start", dut_rises - base_rises, 1);
    trans_write = 1'b0;
    run(OS - 1);
    check("start_width_lo", {31'd0, tx}, 32'd0);
    clk_cycle();
    check("start_width_end", {31'd0, tx}, {31'd0, trans_data[0]});
    run(FRAME_LEN);

    // randomized frames: random data, pulse length, mid-frame data changes and gaps
    for (int f = 0; f < 8; f++) begin
      trans_data  = 8'($urandom);
      hold        = $urandom_range(1, 4);
      chg         = $urandom_range(10, 150);
      gap         = $urandom_range(0, 12);
      trans_write = 1'b1;
      run(hold);
      trans_write = 1'b0;
      run(chg);
      trans_data = 8'($urandom);
      run(FRAME_LEN + 1 - hold - chg + gap);
    end
    run(FRAME_LEN + 5);
    check("rx_drained", exp_bytes.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
